instruction_fetcher: RTL and testbench

INSTRUCTION_FETCHER -- requirements
Module: instruction_fetcher

---
 rtl/instruction_fetcher_pkg.sv | 32 +++
 rtl/instruction_fetcher_icache.sv | 51 +++++
 rtl/instruction_fetcher.sv | 144 ++++++++++++++
 tb/tb_instruction_fetcher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg
// Shared constants and types for the instruction fetcher and its cache:
// address/instruction word types, boolean constants, the zero word, cache
// index/tag widths for the default geometry, and the fetcher state type.
package instruction_fetcher_pkg;

  typedef logic [31:0] ADDR_TYPE;
  typedef logic [31:0] INST_TYPE;

  localparam logic     TRUE      = 1'b1;
  localparam logic     FALSE     = 1'b0;
  localparam INST_TYPE ZERO_WORD = '0;

  // Index covers pc[idx_w+1:2]; the tag is everything above it.
  function automatic int unsigned icache_idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned icache_tag_w(input int unsigned lines);
    return 32 - $clog2(lines) - 2;
  endfunction

  localparam int unsigned ICACHE_LINES_DEFAULT = 256;
  localparam int unsigned ICACHE_IDX_W = icache_idx_w(ICACHE_LINES_DEFAULT);
  localparam int unsigned ICACHE_TAG_W = icache_tag_w(ICACHE_LINES_DEFAULT);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetcher_icache.sv
// icache
// Direct-mapped, one-word-per-line instruction cache.
//   clk, rst         : clock; synchronous active-high clear of all valid bits
//   rd_idx, rd_tag   : lookup line index and tag (combinational read)
//   hit, rd_data     : lookup result and the stored word
//   wr_en            : write one line (synchronous)
//   wr_idx, wr_tag   : line index and tag being written
//   wr_data          : word being written
module icache
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned LINES = ICACHE_LINES_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [icache_idx_w(LINES)-1:0] rd_idx,
  input  logic [icache_tag_w(LINES)-1:0] rd_tag,
  output logic                           hit,
  output logic [31:0]                    rd_data,
  input  logic                           wr_en,
  input  logic [icache_idx_w(LINES)-1:0] wr_idx,
  input  logic [icache_tag_w(LINES)-1:0] wr_tag,
  input  logic [31:0]                    wr_data
);

  localparam int unsigned TAG_W = icache_tag_w(LINES);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  INST_TYPE         data_mem [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= TRUE;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher
// Fetches instruction words one at a time, either from a small direct-mapped
// cache (one-cycle hit) or from the memory controller through a one-entry
// hold register. At most one memory request is ever outstanding.
// Build option: define ICACHE_EN to include the cache; otherwise every
// lookup misses and each instruction is fetched from memory.
//   clk, rst              : clock; synchronous active-high reset
//   rdy                   : global enable, low freezes all state
//   start_query_signal    : one-cycle fetch request pulse
//   pc_to_mc              : request address
//   finish_query_signal   : one-cycle completion pulse
//   inst_from_mc          : fetched word
//   issue_stall           : downstream full, blocks emission
//   inst_valid            : one-cycle pulse per emitted instruction
//   inst_out, pc_out      : emitted instruction and its address
//   flush, target_pc      : redirect to target_pc, highest priority
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = 256,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        start_query_signal,
  output logic [31:0] pc_to_mc,
  input  logic        finish_query_signal,
  input  logic [31:0] inst_from_mc,
  input  logic        issue_stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  input  logic        flush,
  input  logic [31:0] target_pc
);

  if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
    $error("ICACHE_LINES must be a power of two of at least 2");
  end

  fetch_state_t state, state_next;
  ADDR_TYPE     pc;
  logic         hold_valid;
  INST_TYPE     hold_inst;

  logic     hit;
  INST_TYPE cache_inst;
  logic     emit_hold, emit_hit, issue_req, accept_fill;

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = icache_idx_w(ICACHE_LINES);

  icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc[IDX_W+1:2]),
    .rd_tag  (pc[31:IDX_W+2]),
    .hit     (hit),
    .rd_data (cache_inst),
    .wr_en   (rdy && !rst && accept_fill),
    .wr_idx  (pc[IDX_W+1:2]),
    .wr_tag  (pc[31:IDX_W+2]),
    .wr_data (inst_from_mc)
  );
`else
  assign hit        = FALSE;
  assign cache_inst = ZERO_WORD;
`endif

  // Next state: flush always returns to IDLE; a miss in IDLE issues a request
  // regardless of issue_stall.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (!hold_valid && !hit) state_next = WAIT_MEM;
        WAIT_MEM: if (finish_query_signal) state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
  end

  // Per-cycle actions; flush suppresses all of them, including a completion
  // arriving in the same cycle.
  always_comb begin
    emit_hold   = FALSE;
    emit_hit    = FALSE;
    issue_req   = FALSE;
    accept_fill = FALSE;
    if (!flush) begin
      case (state)
        IDLE: begin
          if (hold_valid)  emit_hold = !issue_stall;
          else if (hit)    emit_hit  = !issue_stall;
          else             issue_req = TRUE;
        end
        WAIT_MEM: accept_fill = finish_query_signal;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      pc                 <= RESET_PC;
      hold_valid         <= FALSE;
      hold_inst          <= ZERO_WORD;
      start_query_signal <= FALSE;
      pc_to_mc           <= ZERO_WORD;
      inst_valid         <= FALSE;
      inst_out           <= ZERO_WORD;
      pc_out             <= ZERO_WORD;
    end else if (!rdy) begin
      start_query_signal <= FALSE;
      inst_valid         <= FALSE;
    end else begin
      state              <= state_next;
      start_query_signal <= issue_req;
      inst_valid         <= emit_hold || emit_hit;
      if (issue_req) pc_to_mc <= pc;
      if (emit_hold || emit_hit) begin
        inst_out <= emit_hold ? hold_inst : cache_inst;
        pc_out   <= pc;
        pc       <= pc + 32'd4;
      end
      if (flush) begin
        pc         <= target_pc;
        hold_valid <= FALSE;
      end else if (emit_hold) begin
        hold_valid <= FALSE;
      end else if (accept_fill) begin
        hold_valid <= TRUE;
        hold_inst  <= inst_from_mc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher
// Directed scenarios followed by a randomized run. The bench plays the memory
// controller over a synthetic program image and keeps a transaction-level
// reference: the next address expected to be emitted, and which address each
// cache line holds (only when ICACHE_EN is defined).
module tb_instruction_fetcher;

  localparam int unsigned LINES  = 256;
  localparam logic [31:0] RST_PC = 32'h0;
`ifdef ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, rdy, start_query_signal, finish_query_signal;
  logic        issue_stall, inst_valid, flush;
  logic [31:0] pc_to_mc, inst_from_mc, inst_out, pc_out, target_pc;

  instruction_fetcher #(
    .ICACHE_LINES(LINES),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rdy                 (rdy),
    .start_query_signal  (start_query_signal),
    .pc_to_mc            (pc_to_mc),
    .finish_query_signal (finish_query_signal),
    .inst_from_mc        (inst_from_mc),
    .issue_stall         (issue_stall),
    .inst_valid          (inst_valid),
    .inst_out            (inst_out),
    .pc_out              (pc_out),
    .flush               (flush),
    .target_pc           (target_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_pc;
  int unsigned n_emit = 0;
  logic [31:0] resident [int unsigned];
  bit          mc_busy = 1'b0;
  logic [31:0] mc_addr;
  int unsigned mc_cnt = 0;
  int unsigned mc_lat = 0;
  bit          junk_finish = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int unsigned line_of(input logic [31:0] a);
    return (a >> 2) % LINES;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return CACHE_ON && resident.exists(line_of(a)) && (resident[line_of(a)] == a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic iv, input logic sq);
    check({tag, "_inst_valid"}, inst_valid, iv);
    check({tag, "_start_query"}, start_query_signal, sq);
  endtask

  // One clock: apply inputs (plus the memory response), advance, then update
  // the reference and check what the DUT did at that edge.
  task automatic step(input bit r, input bit st, input bit fl, input logic [31:0] tgt);
    rdy = r; issue_stall = st; flush = fl; target_pc = tgt;
    finish_query_signal = 1'b0;
    inst_from_mc        = $urandom;
    if (junk_finish) begin
      finish_query_signal = 1'b1;
      inst_from_mc        = 32'hDEAD_BEEF;
      junk_finish         = 1'b0;
    end else if (r && mc_busy && mc_cnt == 0) begin
      finish_query_signal = 1'b1;
      inst_from_mc        = mem_word(mc_addr);
    end
    @(posedge clk); #1;
    if (r) begin
      if (mc_busy && finish_query_signal) begin
        mc_busy = 1'b0;
        if (!fl) resident[line_of(mc_addr)] = mc_addr;
      end else if (mc_busy) begin
        mc_cnt--;
      end
      if (fl) mc_busy = 1'b0;
    end else begin
      expect_out("frozen", 1'b0, 1'b0);
    end
    if (inst_valid) begin
      check("emit_pc", pc_out, exp_pc);
      check("emit_inst", inst_out, mem_word(exp_pc));
      check("emit_gating", {st, fl, ~r}, 32'h0);
      exp_pc += 32'd4;
      n_emit++;
    end
    if (start_query_signal) begin
      check("one_outstanding", mc_busy, 32'h0);
      check("req_pc", pc_to_mc, exp_pc);
      check("req_on_miss", model_hit(exp_pc), 32'h0);
      mc_busy = 1'b1;
      mc_addr = exp_pc;
      mc_cnt  = mc_lat;
    end
    if (r && fl) begin
      check("flush_quiet", {inst_valid, start_query_signal}, 32'h0);
      exp_pc = tgt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; issue_stall = 1'b0; flush = 1'b0; target_pc = '0;
    finish_query_signal = 1'b0; inst_from_mc = '0;
    @(posedge clk); #1;
    check("rst_start_query", start_query_signal, 32'h0);
    check("rst_pc_to_mc", pc_to_mc, 32'h0);
    check("rst_inst_valid", inst_valid, 32'h0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    rst = 1'b0;
    exp_pc = RST_PC;
    resident.delete();
    mc_busy = 1'b0;
  endtask

  task automatic run_emits(input int unsigned n, input int unsigned budget, input string tag);
    int unsigned goal;
    int unsigned c;
    goal = n_emit + n;
    c = 0;
    while (n_emit < goal && c < budget) begin
      step(1'b1, 1'b0, 1'b0, '0);
      c++;
    end
    check(tag, n_emit >= goal, 32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r, st, fl;
    logic [31:0] tgt;
    int unsigned e0;

    // Reset and first miss at RESET_PC
    mc_lat = 0;
    do_reset();
    step(1, 0, 0, '0); expect_out("first_req", 0, 1);
    check("first_req_addr", pc_to_mc, 32'h0);
    step(1, 0, 0, '0); expect_out("first_fill", 0, 0);
    step(1, 0, 0, '0); expect_out("first_emit", 1, 0);
    check("first_emit_inst", inst_out, 32'h0000_0013);
    check("first_emit_pc", pc_out, 32'h0);
    step(1, 0, 0, '0); expect_out("second_req", 0, 1);
    check("second_req_addr", pc_to_mc, 32'h4);

    // Hold register waits out a long stall, then emits once
    step(1, 1, 0, '0); expect_out("stall_fill", 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, '0); expect_out("stall_hold", 0, 0);
    end
    step(1, 0, 0, '0); expect_out("stall_release", 1, 0);
    check("stall_release_pc", pc_out, 32'h4);
    step(1, 0, 0, '0); expect_out("after_release", 0, 1);
    check("after_release_addr", pc_to_mc, 32'h8);

    // Flush while completion arrives in the same cycle
    step(1, 0, 1, 32'h100); expect_out("flush_with_finish", 0, 0);
    step(1, 0, 0, '0); expect_out("flush_req", 0, 1);
    check("flush_req_addr", pc_to_mc, 32'h100);
    run_emits(1, 20, "flush_emit_timeout");

    // Reset while a request is outstanding, stale completion right after
    mc_lat = 6;
    step(1, 0, 0, '0); expect_out("long_req", 0, 1);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    do_reset();
    mc_lat = 0;
    junk_finish = 1'b1;
    step(1, 0, 0, '0); expect_out("post_reset_req", 0, 1);
    check("post_reset_addr", pc_to_mc, RST_PC);
    run_emits(1, 20, "post_reset_timeout");

    // Aliasing lines 0x0 and 0x400
    step(1, 0, 1, 32'h400); expect_out("alias_flush", 0, 0);
    step(1, 0, 0, '0); expect_out("alias_req", 0, 1);
    check("alias_req_addr", pc_to_mc, 32'h400);
    run_emits(1, 20, "alias_emit_timeout");
    step(1, 0, 1, 32'h0); expect_out("refetch_flush", 0, 0);
    step(1, 0, 0, '0); expect_out("refetch_req", 0, 1);
    check("refetch_addr", pc_to_mc, 32'h0);
    run_emits(1, 20, "refetch_timeout");

`ifdef ICACHE_EN
    // Warm 0x0-0xC, then replay as a back-to-back hit stream
    step(1, 0, 1, 32'h0);
    run_emits(4, 80, "warm_timeout");
    step(1, 0, 1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, '0); expect_out("hit_stream", 1, 0);
      check("hit_stream_pc", pc_out, 32'(i * 4));
    end
    // Freeze in the middle of a hit stream
    step(1, 0, 1, 32'h0);
    step(1, 0, 0, '0); expect_out("hit_pre_freeze", 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0); expect_out("hit_frozen", 0, 0);
    end
    step(1, 0, 0, '0); expect_out("hit_resume", 1, 0);
    check("hit_resume_pc", pc_out, 32'h4);
`endif

    // Freeze with a word waiting in the hold register
    step(1, 0, 1, 32'h40);
    step(1, 0, 0, '0); expect_out("freeze_req", 0, 1);
    step(1, 0, 0, '0); expect_out("freeze_fill", 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, '0); expect_out("freeze_hold", 0, 0);
    end
    step(1, 0, 0, '0); expect_out("freeze_resume", 1, 0);
    check("freeze_resume_pc", pc_out, 32'h40);

    // Address wrap at the top of memory
    step(1, 0, 1, 32'hFFFF_FFF8);
    run_emits(3, 40, "wrap_timeout");

    // Randomized traffic
    e0 = n_emit;
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = r && ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 + 32'($urandom_range(0, 7) << 2);
      else                           tgt = 32'($urandom_range(0, 511) << 2);
      if (!mc_busy) mc_lat = $urandom_range(0, 4);
      step(r, st, fl, tgt);
    end
    check("random_progress", (n_emit - e0) >= 50, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
